// File: rtl/wb_pipe_reg_pkg.sv
// Shared types and constants for the MEM->WB stage register and its skid buffer.
// Contents: default widths, write-back payload struct, occupancy state
// encoding, and the hard-wired zero register index.
package pipe_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int RD_W_DEF   = 5;

  // Register index that never gets written (x0).
  localparam int unsigned ZERO_REG = 0;

  // Payload carried from MEM to WB, at the default widths.
  typedef struct packed {
    logic                  memtoreg;
    logic                  regwrite;
    logic [RD_W_DEF-1:0]   rd;
    logic [DATA_W_DEF-1:0] result;
    logic [DATA_W_DEF-1:0] rdata;
  } wb_payload_t;

  // Occupancy states. The encoding equals the number of held entries, so
  // the state register is also the registered occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_t;

endpackage

// File: rtl/wb_pipe_reg_if.sv
// MEM->WB handshake bundle: upstream entry (in_*) and downstream head (out_*).
// Ports: in_valid/in_ready plus payload fields in; out_valid/out_ready plus
// rd, wen and wdata out. slave = the stage register, master = its environment.
interface wb_pipe_reg_if #(
  parameter int DATA_W = 64,
  parameter int RD_W   = 5
);
  logic              in_valid;
  logic              in_ready;
  logic              in_memtoreg;
  logic              in_regwrite;
  logic [RD_W-1:0]   in_rd;
  logic [DATA_W-1:0] in_result;
  logic [DATA_W-1:0] in_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [RD_W-1:0]   out_rd;
  logic              out_wen;
  logic [DATA_W-1:0] out_wdata;

  modport slave (
    input  in_valid, in_memtoreg, in_regwrite, in_rd, in_result, in_rdata,
    input  out_ready,
    output in_ready, out_valid, out_rd, out_wen, out_wdata
  );

  modport master (
    output in_valid, in_memtoreg, in_regwrite, in_rd, in_result, in_rdata,
    output out_ready,
    input  in_ready, out_valid, out_rd, out_wen, out_wdata
  );
endinterface

// File: rtl/wb_pipe_reg_skid_buf.sv
// Generic two-entry skid buffer (main = head, skid = overflow) with flush.
// Ports: clk/reset, flush, in valid/ready/data, out valid/ready/data, occupancy.
// Latency 1 cycle when empty; in_ready is a pure register output (!skid valid).
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   occupancy
);

  skid_state_t  state, state_nxt;
  logic [W-1:0] main_q, skid_q;
  logic         accept, complete;
  logic         load_main_in, load_main_skid, load_skid;

  assign in_ready  = (state != ST_TWO);
  assign out_valid = (state != ST_EMPTY);
  assign out_data  = main_q;
  assign occupancy = state;
  assign accept    = in_valid & in_ready;
  assign complete  = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      // Flush wins; any simultaneous accept is dropped.
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state_nxt    = ST_ONE;
            load_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && complete) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_nxt = ST_TWO;
            load_skid = 1'b1;
          end else if (complete) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (complete) begin
            state_nxt      = ST_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Payload is left untouched by flush; the valid state gates it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)        main_q <= in_data;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_data;
    end
  end

endmodule

// File: rtl/wb_pipe_reg.sv
// MEM->WB stage register: flow-controlled hold of the payload, write-back mux
// and register-file write enable. Ports: clk/reset, flush, bus (slave), occupancy.
// Latency 1 cycle; SKID=1 registered in_ready (2 entries), SKID=0 combinational.
module wb_pipe_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_W   = RD_W_DEF,
  parameter bit SKID   = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  wb_pipe_reg_if.slave        bus,
  output logic [1:0]          occupancy
);

  // Same layout as wb_payload_t, but following this instance's widths.
  typedef struct packed {
    logic              memtoreg;
    logic              regwrite;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] rdata;
  } payload_t;

  payload_t in_pl, head;
  logic     head_vld, rdy;

  assign in_pl = {bus.in_memtoreg, bus.in_regwrite, bus.in_rd,
                  bus.in_result, bus.in_rdata};

  generate
    if (SKID) begin : g_skid
      pipe_skid_buf #(.W($bits(payload_t))) u_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (bus.in_valid),
        .in_ready  (rdy),
        .in_data   (in_pl),
        .out_valid (head_vld),
        .out_ready (bus.out_ready),
        .out_data  (head),
        .occupancy (occupancy)
      );
    end else begin : g_single
      logic     vld_q;
      payload_t dat_q;

      // A full register can still accept when its entry leaves this cycle.
      assign rdy       = !vld_q | bus.out_ready;
      assign head_vld  = vld_q;
      assign head      = dat_q;
      assign occupancy = {1'b0, vld_q};

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          vld_q <= 1'b0;
          dat_q <= '0;
        end else if (flush) begin
          vld_q <= 1'b0;
        end else if (bus.in_valid && rdy) begin
          vld_q <= 1'b1;
          dat_q <= in_pl;
        end else if (bus.out_ready) begin
          vld_q <= 1'b0;
        end
      end
    end
  endgenerate

  assign bus.in_ready  = rdy;
  assign bus.out_valid = head_vld;
  assign bus.out_rd    = head.rd;
  assign bus.out_wdata = head.memtoreg ? head.rdata : head.result;
  assign bus.out_wen   = head_vld & head.regwrite & (head.rd != RD_W'(ZERO_REG));

endmodule
